// File: rtl/y86_dmem_stage_if.sv
// Request/response bundle between the execute stage and the data-memory stage.
// master = execute side (drives the request), slave = memory stage.
interface y86_dmem_stage_if;
  logic        in_valid;
  logic [3:0]  icode;
  logic [63:0] valA;
  logic [63:0] valE;
  logic [63:0] valP;
  logic        busy;
  logic        out_valid;
  logic [63:0] valM;
  logic        dmem_error;

  modport master (
    output in_valid, icode, valA, valE, valP,
    input  busy, out_valid, valM, dmem_error
  );

  modport slave (
    input  in_valid, icode, valA, valE, valP,
    output busy, out_valid, valM, dmem_error
  );
endinterface

// File: rtl/y86_dmem_stage.sv
// Multi-cycle Y86-64 data-memory stage: decodes the memory operation, performs an
// 8-byte little-endian access after a configurable number of wait cycles and
// returns a single-cycle response pulse with read data and an error flag.
module y86_dmem_stage #(
  parameter int unsigned MEM_BYTES   = 512,
  parameter int unsigned LATENCY     = 2,
  parameter bit          ALIGN_CHECK = 1'b0
) (
  input logic             clk,
  input logic             reset,
  y86_dmem_stage_if.slave dmem
);

  localparam int unsigned    IdxW    = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int unsigned    CntW    = 5;
  // Highest legal base address of an 8-byte access.
  localparam logic [63:0]    MaxAddr = 64'(MEM_BYTES - 8);
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  typedef enum logic [1:0] {
    OpNone,
    OpRead,
    OpWrite
  } op_e;

  // State and captured request.
  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  op_e             r_op;
  logic [IdxW-1:0] r_idx;
  logic [63:0]     r_wdata;
  logic            r_err;
  // Response registers, held until the next response.
  logic [63:0]     r_valm;
  logic            r_derr;

  logic [7:0]      r_mem [MEM_BYTES];

  // Decode of the live request.
  op_e             w_in_op;
  logic [63:0]     w_in_addr;
  logic [63:0]     w_in_wdata;
  logic            w_in_err;

  // Operation actually committed this cycle (live in IDLE, captured otherwise).
  op_e             w_op;
  logic [IdxW-1:0] w_base;
  logic [63:0]     w_wdata;
  logic            w_err;

  state_e          w_state_d;
  logic [CntW-1:0] w_cnt_d;
  logic            w_accept;
  logic            w_commit;
  logic            w_wr_en;
  logic [63:0]     w_rdata;
  logic [63:0]     w_valm_d;

  // Decode icode into operation kind, address source and write-data source.
  always_comb begin
    w_in_op    = OpNone;
    w_in_addr  = dmem.valE;
    w_in_wdata = dmem.valA;
    case (dmem.icode)
      4'h4: w_in_op = OpWrite;                       // rmmovq
      4'h5: w_in_op = OpRead;                        // mrmovq
      4'h8: begin                                    // call
        w_in_op    = OpWrite;
        w_in_wdata = dmem.valP;
      end
      4'h9: begin                                    // ret
        w_in_op   = OpRead;
        w_in_addr = dmem.valA;
      end
      4'hA: w_in_op = OpWrite;                       // pushq
      4'hB: begin                                    // popq
        w_in_op   = OpRead;
        w_in_addr = dmem.valA;
      end
      default: w_in_op = OpNone;
    endcase
  end

  // Full 64-bit range check; no-ops never report an error.
  always_comb begin
    w_in_err = 1'b0;
    if (w_in_op != OpNone) begin
      w_in_err = (w_in_addr > MaxAddr);
      if (ALIGN_CHECK && (w_in_addr[2:0] != 3'd0)) begin
        w_in_err = 1'b1;
      end
    end
  end

  // With LATENCY=1 the commit happens on the accept edge, so use the live request in IDLE.
  always_comb begin
    if (r_state == StIdle) begin
      w_op    = w_in_op;
      w_wdata = w_in_wdata;
      w_err   = w_in_err;
      w_base  = w_in_err ? '0 : w_in_addr[IdxW-1:0];
    end else begin
      w_op    = r_op;
      w_wdata = r_wdata;
      w_err   = r_err;
      w_base  = r_err ? '0 : r_idx;
    end
  end

  // Next-state and wait counter.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (dmem.in_valid) begin
          if ((w_in_op != OpNone) && (LATENCY > 1)) begin
            w_state_d = StWait;
            w_cnt_d   = CntLoad;
          end else begin
            w_state_d = StResp;
          end
        end
      end
      StWait: begin
        w_cnt_d = r_cnt - 1'b1;
        if (r_cnt == CntW'(1)) begin
          w_state_d = StResp;
        end
      end
      StResp: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  assign w_accept = (r_state == StIdle) && dmem.in_valid;
  // Write commit and read sample both occur on the edge that enters RESP.
  assign w_commit = (r_state != StResp) && (w_state_d == StResp);
  // Reset wins over a commit on the same edge, so an aborted write never lands.
  assign w_wr_en  = w_commit && !reset && (w_op == OpWrite) && !w_err;

  // Little-endian 8-byte gather from the base address.
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      w_rdata[8*i +: 8] = r_mem[w_base + IdxW'(i)];
    end
  end

  // Only good reads return data; writes, errors and no-ops return zero.
  always_comb begin
    w_valm_d = '0;
    if ((w_op == OpRead) && !w_err) begin
      w_valm_d = w_rdata;
    end
  end

  // FSM state, request capture and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_op    <= OpNone;
      r_idx   <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_valm  <= '0;
      r_derr  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_accept) begin
        r_op    <= w_in_op;
        r_idx   <= w_in_addr[IdxW-1:0];
        r_wdata <= w_in_wdata;
        r_err   <= w_in_err;
      end
      if (w_commit) begin
        r_valm <= w_valm_d;
        r_derr <= w_err;
      end
    end
  end

  // Byte-wide storage; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 8; i++) begin
        r_mem[w_base + IdxW'(i)] <= w_wdata[8*i +: 8];
      end
    end
  end

  assign dmem.busy       = (r_state != StIdle);
  assign dmem.out_valid  = (r_state == StResp);
  assign dmem.valM       = r_valm;
  assign dmem.dmem_error = r_derr;

endmodule

// File: tb/tb_y86_dmem_stage.sv
// Bench for y86_dmem_stage: instance A (LATENCY=2, no alignment check) and
// instance B (LATENCY=4, alignment check) against a byte-array reference model.
module tb_y86_dmem_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  y86_dmem_stage_if bus_a ();
  y86_dmem_stage_if bus_b ();

  y86_dmem_stage #(.MEM_BYTES(512), .LATENCY(2), .ALIGN_CHECK(1'b0)) dut_a (
    .clk  (clk),
    .reset(reset),
    .dmem (bus_a)
  );

  y86_dmem_stage #(.MEM_BYTES(512), .LATENCY(4), .ALIGN_CHECK(1'b1)) dut_b (
    .clk  (clk),
    .reset(reset),
    .dmem (bus_b)
  );

  // Reference memory image per instance.
  logic [7:0] mdl [2][512];

  function automatic logic f_ov(input int sel);
    return (sel == 0) ? bus_a.out_valid : bus_b.out_valid;
  endfunction
  function automatic logic f_busy(input int sel);
    return (sel == 0) ? bus_a.busy : bus_b.busy;
  endfunction
  function automatic logic [63:0] f_valm(input int sel);
    return (sel == 0) ? bus_a.valM : bus_b.valM;
  endfunction
  function automatic logic f_err(input int sel);
    return (sel == 0) ? bus_a.dmem_error : bus_b.dmem_error;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [3:0] ic,
                       input logic [63:0] a, input logic [63:0] e, input logic [63:0] p);
    if (sel == 0) begin
      bus_a.in_valid = v; bus_a.icode = ic; bus_a.valA = a; bus_a.valE = e; bus_a.valP = p;
    end else begin
      bus_b.in_valid = v; bus_b.icode = ic; bus_b.valA = a; bus_b.valE = e; bus_b.valP = p;
    end
  endtask

  // Spec-level model: resolve operation, check range/alignment, update byte image.
  task automatic model_access(input int sel, input logic [3:0] ic, input logic [63:0] a,
                              input logic [63:0] e, input logic [63:0] p,
                              output logic [63:0] valm, output logic err, output int lat,
                              output logic is_wr);
    logic rd;
    logic [63:0] addr;
    logic [63:0] data;
    rd = 1'b0; is_wr = 1'b0; addr = e; data = a;
    case (ic)
      4'h4: is_wr = 1'b1;
      4'h5: rd = 1'b1;
      4'h8: begin is_wr = 1'b1; data = p; end
      4'h9: begin rd = 1'b1; addr = a; end
      4'hA: is_wr = 1'b1;
      4'hB: begin rd = 1'b1; addr = a; end
      default: ;
    endcase
    err  = (rd || is_wr) && ((addr > 64'd504) || (sel == 1 && addr[2:0] != 3'd0));
    lat  = (rd || is_wr) ? ((sel == 1) ? 4 : 2) : 1;
    valm = '0;
    if (!err) begin
      for (int i = 0; i < 8; i++) begin
        if (is_wr) mdl[sel][int'(addr) + i] = data[8*i +: 8];
        if (rd) valm[8*i +: 8] = mdl[sel][int'(addr) + i];
      end
    end
  endtask

  // Issue one request from IDLE and collect its response (bounded wait).
  task automatic issue(input int sel, input logic [3:0] ic, input logic [63:0] a,
                       input logic [63:0] e, input logic [63:0] p,
                       output logic [63:0] got_valm, output logic got_err, output int got_lat,
                       output logic got_tail, output logic [63:0] exp_valm,
                       output logic exp_err, output int exp_lat, output logic exp_wr);
    @(negedge clk);
    drive(sel, 1'b1, ic, a, e, p);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, ic, a, e, p);
    got_lat = -1; got_valm = '0; got_err = 1'b0; got_tail = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (f_ov(sel)) begin
        got_lat = k; got_valm = f_valm(sel); got_err = f_err(sel);
        break;
      end
      @(posedge clk);
    end
    if (got_lat > 0) begin
      @(posedge clk);
      #1;
      got_tail = f_ov(sel);
    end
    model_access(sel, ic, a, e, p, exp_valm, exp_err, exp_lat, exp_wr);
  endtask

  logic [63:0] gv, ev;
  logic        ge, ee, gt, ew;
  int          gl, el;

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 1'b0, 4'h0, '0, '0, '0);
    drive(1, 1'b0, 4'h0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus_a.busy); end
    n_checks++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus_a.out_valid); end
    n_checks++; if (bus_a.valM !== 64'd0) begin n_fail++; $display("FAIL reset_valM got=%h exp=0", bus_a.valM); end
    n_checks++; if (bus_a.dmem_error !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", bus_a.dmem_error); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Zero both memories through the normal write path so the model starts known.
  task automatic clear_mem();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 64; k++) begin
        issue(s, 4'h4, 64'd0, 64'(8 * k), 64'd0, gv, ge, gl, gt, ev, ee, el, ew);
      end
    end
  endtask

  task automatic test_basic();
    issue(0, 4'h4, 64'hA5A5A5A5A5A5A5A5, 64'd0, 64'd0, gv, ge, gl, gt, ev, ee, el, ew);
    n_checks++; if (gl !== 2) begin n_fail++; $display("FAIL basic_wr_latency got=%0d exp=2", gl); end
    n_checks++; if (ge !== 1'b0) begin n_fail++; $display("FAIL basic_wr_err got=%b exp=0", ge); end
    n_checks++; if (gt !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width got=%b exp=0", gt); end
    issue(0, 4'h5, 64'd0, 64'd0, 64'd0, gv, ge, gl, gt, ev, ee, el, ew);
    n_checks++; if (gl !== 2) begin n_fail++; $display("FAIL basic_rd_latency got=%0d exp=2", gl); end
    n_checks++; if (gv !== 64'hA5A5A5A5A5A5A5A5) begin n_fail++; $display("FAIL basic_rd_valM got=%h exp=a5a5a5a5a5a5a5a5", gv); end
  endtask

  task automatic test_bounds();
    logic [63:0] w;
    w = {$urandom, $urandom};
    issue(0, 4'h4, w, 64'd504, 64'd0, gv, ge, gl, gt, ev, ee, el, ew);
    n_checks++; if (ge !== 1'b0) begin n_fail++; $display("FAIL bounds_504_wr_err got=%b exp=0", ge); end
    issue(0, 4'h4, ~w, 64'd505, 64'd0, gv, ge, gl, gt, ev, ee, el, ew);
    n_checks++; if (ge !== 1'b1) begin n_fail++; $display("FAIL bounds_505_err got=%b exp=1", ge); end
    n_checks++; if (gv !== 64'd0) begin n_fail++; $display("FAIL bounds_505_valM got=%h exp=0", gv); end
    n_checks++; if (gl !== 2) begin n_fail++; $display("FAIL bounds_505_latency got=%0d exp=2", gl); end
    issue(0, 4'h5, 64'd0, 64'd504, 64'd0, gv, ge, gl, gt, ev, ee, el, ew);
    n_checks++; if (ge !== 1'b0) begin n_fail++; $display("FAIL bounds_504_rd_err got=%b exp=0", ge); end
    n_checks++; if (gv !== w) begin n_fail++; $display("FAIL bounds_504_rd_valM got=%h exp=%h", gv, w); end
    issue(0, 4'h5, 64'd0, 64'hFFFFFFFFFFFFFFF8, 64'd0, gv, ge, gl, gt, ev, ee, el, ew);
    n_checks++; if (ge !== 1'b1) begin n_fail++; $display("FAIL bounds_wrap_err got=%b exp=1", ge); end
    n_checks++; if (gv !== 64'd0) begin n_fail++; $display("FAIL bounds_wrap_valM got=%h exp=0", gv); end
  endtask

  task automatic test_stack();
    issue(0, 4'h8, 64'd0, 64'd16, 64'd256, gv, ge, gl, gt, ev, ee, el, ew);
    issue(0, 4'h9, 64'd16, 64'd0, 64'd0, gv, ge, gl, gt, ev, ee, el, ew);
    n_checks++; if (gv !== 64'd256) begin n_fail++; $display("FAIL stack_ret_valM got=%h exp=100", gv); end
    issue(0, 4'hA, 64'hDEADBEEFDEADBEEF, 64'd32, 64'd0, gv, ge, gl, gt, ev, ee, el, ew);
    issue(0, 4'hB, 64'd32, 64'd0, 64'd0, gv, ge, gl, gt, ev, ee, el, ew);
    n_checks++; if (gv !== 64'hDEADBEEFDEADBEEF) begin n_fail++; $display("FAIL stack_pop_valM got=%h exp=deadbeefdeadbeef", gv); end
    n_checks++; if (ge !== 1'b0) begin n_fail++; $display("FAIL stack_pop_err got=%b exp=0", ge); end
  endtask

  task automatic test_unaligned();
    issue(0, 4'h4, 64'hCAFEBABECAFEBABE, 64'd3, 64'd0, gv, ge, gl, gt, ev, ee, el, ew);
    issue(0, 4'h4, 64'hDEADDEADDEADDEAD, 64'd3, 64'd0, gv, ge, gl, gt, ev, ee, el, ew);
    issue(0, 4'h5, 64'd0, 64'd3, 64'd0, gv, ge, gl, gt, ev, ee, el, ew);
    n_checks++; if (gv !== 64'hDEADDEADDEADDEAD) begin n_fail++; $display("FAIL unaligned_rd3 got=%h exp=deaddeaddeaddead", gv); end
    // Bytes 0..2 still hold A5 from the basic test; bytes 3..7 hold the low 5 bytes written.
    issue(0, 4'h5, 64'd0, 64'd0, 64'd0, gv, ge, gl, gt, ev, ee, el, ew);
    n_checks++; if (gv !== 64'hADDEADDEADA5A5A5) begin n_fail++; $display("FAIL unaligned_rd0 got=%h exp=addeaddeada5a5a5", gv); end
    issue(1, 4'h4, 64'hCAFEBABECAFEBABE, 64'd3, 64'd0, gv, ge, gl, gt, ev, ee, el, ew);
    n_checks++; if (ge !== 1'b1) begin n_fail++; $display("FAIL align_err got=%b exp=1", ge); end
    n_checks++; if (gl !== 4) begin n_fail++; $display("FAIL align_err_latency got=%0d exp=4", gl); end
    issue(1, 4'h5, 64'd0, 64'd0, 64'd0, gv, ge, gl, gt, ev, ee, el, ew);
    n_checks++; if (gv !== 64'd0) begin n_fail++; $display("FAIL align_no_write got=%h exp=0", gv); end
  endtask

  task automatic test_noop();
    issue(0, 4'h0, 64'h1111, 64'hFFFFFFFFFFFFFFFF, 64'd0, gv, ge, gl, gt, ev, ee, el, ew);
    n_checks++; if (gl !== 1) begin n_fail++; $display("FAIL noop_latency got=%0d exp=1", gl); end
    n_checks++; if (gv !== 64'd0) begin n_fail++; $display("FAIL noop_valM got=%h exp=0", gv); end
    n_checks++; if (ge !== 1'b0) begin n_fail++; $display("FAIL noop_err got=%b exp=0", ge); end
    issue(1, 4'h7, 64'd0, 64'd3, 64'd0, gv, ge, gl, gt, ev, ee, el, ew);
    n_checks++; if (gl !== 1 || ge !== 1'b0) begin n_fail++; $display("FAIL noop_b lat=%0d err=%b exp lat=1 err=0", gl, ge); end
  endtask

  // Held in_valid on the LATENCY=4 instance: one accept per 5 cycles.
  task automatic test_handshake();
    int busy_cnt = 0;
    int ov_cnt = 0;
    int first_ov = -1;
    @(negedge clk);
    drive(1, 1'b1, 4'h5, 64'd0, 64'd0, 64'd0);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      busy_cnt += int'(bus_b.busy);
      ov_cnt += int'(bus_b.out_valid);
      if (bus_b.out_valid && first_ov < 0) first_ov = c;
    end
    drive(1, 1'b0, 4'h0, 64'd0, 64'd0, 64'd0);
    @(posedge clk);
    @(posedge clk);
    n_checks++; if (busy_cnt !== 16) begin n_fail++; $display("FAIL hs_busy_cycles got=%0d exp=16", busy_cnt); end
    n_checks++; if (ov_cnt !== 4) begin n_fail++; $display("FAIL hs_accepts got=%0d exp=4", ov_cnt); end
    n_checks++; if (first_ov !== 3) begin n_fail++; $display("FAIL hs_first_resp got=%0d exp=3", first_ov); end
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] v;
    int ov_cnt = 0;
    v = {1'b1, 31'($urandom), $urandom};
    issue(0, 4'h4, v, 64'd8, 64'd0, gv, ge, gl, gt, ev, ee, el, ew);
    issue(0, 4'h5, 64'd0, 64'd8, 64'd0, gv, ge, gl, gt, ev, ee, el, ew);
    n_checks++; if (gv !== v) begin n_fail++; $display("FAIL rst_pre_read got=%h exp=%h", gv, v); end
    @(negedge clk);
    drive(0, 1'b1, 4'h4, 64'h1234, 64'd8, 64'd0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 4'h0, 64'd0, 64'd0, 64'd0);
    @(negedge clk);
    n_checks++; if (bus_a.busy !== 1'b1) begin n_fail++; $display("FAIL rst_in_wait_busy got=%b exp=1", bus_a.busy); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (bus_a.busy !== 1'b0 || bus_a.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_abort_ctrl busy=%b ov=%b exp 0 0", bus_a.busy, bus_a.out_valid); end
    n_checks++; if (bus_a.valM !== 64'd0 || bus_a.dmem_error !== 1'b0) begin
      n_fail++; $display("FAIL rst_abort_data valM=%h err=%b exp 0 0", bus_a.valM, bus_a.dmem_error); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      ov_cnt += int'(bus_a.out_valid);
    end
    n_checks++; if (ov_cnt !== 0) begin n_fail++; $display("FAIL rst_no_resp got=%0d exp=0", ov_cnt); end
    issue(0, 4'h5, 64'd0, 64'd8, 64'd0, gv, ge, gl, gt, ev, ee, el, ew);
    n_checks++; if (gv !== v) begin n_fail++; $display("FAIL rst_no_commit got=%h exp=%h", gv, v); end
  endtask

  task automatic test_random();
    logic [3:0] codes [8];
    logic [3:0] ic;
    logic [63:0] addr, data, a, e, p;
    int sel, r;
    codes = '{4'h0, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'h7};
    for (int n = 0; n < 80; n++) begin
      sel = int'($urandom_range(0, 1));
      ic = codes[$urandom_range(0, 7)];
      r = int'($urandom_range(0, 9));
      if (r < 5) addr = 64'($urandom_range(0, 63));
      else if (r < 7) addr = 64'($urandom_range(0, 504));
      else if (r == 7) addr = 64'(500 + $urandom_range(0, 15));
      else if (r == 8) addr = {$urandom, $urandom};
      else addr = 64'(8 * $urandom_range(0, 7));
      data = {$urandom, $urandom};
      p = {$urandom, $urandom};
      if (ic == 4'h9 || ic == 4'hB) begin a = addr; e = data; end
      else begin a = data; e = addr; end
      issue(sel, ic, a, e, p, gv, ge, gl, gt, ev, ee, el, ew);
      n_checks++; if (gl !== el) begin n_fail++; $display("FAIL rand_latency n=%0d ic=%h got=%0d exp=%0d", n, ic, gl, el); end
      n_checks++; if (ge !== ee) begin n_fail++; $display("FAIL rand_err n=%0d ic=%h addr=%h got=%b exp=%b", n, ic, addr, ge, ee); end
      n_checks++; if (gt !== 1'b0) begin n_fail++; $display("FAIL rand_pulse n=%0d got=%b exp=0", n, gt); end
      if (!(ew && !ee)) begin
        n_checks++; if (gv !== ev) begin n_fail++; $display("FAIL rand_valM n=%0d ic=%h addr=%h got=%h exp=%h", n, ic, addr, gv, ev); end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    clear_mem();
    test_basic();
    test_bounds();
    test_stack();
    test_unaligned();
    test_noop();
    test_handshake();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
